// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master shift engine and its APB register
// front end.
//   - spi_state_e        : shift engine FSM encoding (IDLE / SHIFT / DONE)
//   - SPI_RUN/WAIT/STOP  : spi_mode encodings (also used by the APB mode FSM)
//   - HP_CNT_W           : width of the half-period counter (H in 1..1024)
//   - half_period()      : H = (sppr + 1) * 2^spr
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    localparam int HP_CNT_W = 11;

    // Largest value is 8 * 128 = 1024, which still fits in 11 bits.
    function automatic logic [HP_CNT_W-1:0] half_period(input logic [2:0] sppr,
                                                         input logic [2:0] spr);
        logic [HP_CNT_W-1:0] base;
        base = HP_CNT_W'(sppr) + HP_CNT_W'(1);
        return base << spr;
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// -----------------------------------------------------------------------------
// spi_shift_engine_if
// Transmit/receive handshake between the APB register slave and the SPI
// shift engine.
//   send_data_i  : one-cycle transmit request
//   mosi_data_i  : byte to transmit, valid with send_data_i
//   miso_data_o  : last received byte
//   rec_data_o   : one-cycle strobe when miso_data_o updates
//   tip_o        : transfer in progress
// Modports: master = register slave side, slave = shift engine side.
// -----------------------------------------------------------------------------
interface spi_shift_engine_if #(
    parameter int DATA_W = 8
);
    logic              send_data_i;
    logic [DATA_W-1:0] mosi_data_i;
    logic [DATA_W-1:0] miso_data_o;
    logic              rec_data_o;
    logic              tip_o;

    modport master (
        output send_data_i,
        output mosi_data_i,
        input  miso_data_o,
        input  rec_data_o,
        input  tip_o
    );

    modport slave (
        input  send_data_i,
        input  mosi_data_i,
        output miso_data_o,
        output rec_data_o,
        output tip_o
    );
endinterface

// File: rtl/spi_baud_gen.sv
// -----------------------------------------------------------------------------
// spi_baud_gen
// Half-period counter for SCLK. Counts 0..H-1 while enabled and pulses
// edge_tick (combinationally) on the terminal count.
//   pclk, preset : clock, synchronous active-high reset
//   half_period  : latched H (1..1024)
//   enable       : count while high (engine in SHIFT)
//   freeze       : hold count and suppress ticks (STOP mode)
//   clear        : force count to zero
//   edge_tick    : one-cycle pulse on terminal count
// -----------------------------------------------------------------------------
module spi_baud_gen
    import spi_pkg::*;
(
    input  logic                pclk,
    input  logic                preset,
    input  logic [HP_CNT_W-1:0] half_period,
    input  logic                enable,
    input  logic                freeze,
    input  logic                clear,
    output logic                edge_tick
);

    logic [HP_CNT_W-1:0] cnt_reg;
    logic                terminal;

    assign terminal  = (cnt_reg == half_period - HP_CNT_W'(1));
    assign edge_tick = enable && !freeze && terminal;

    always_ff @(posedge pclk) begin
        if (preset || clear) begin
            cnt_reg <= '0;
        end else if (enable && !freeze) begin
            cnt_reg <= terminal ? '0 : cnt_reg + HP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
// SPI master serializer. Takes a transmit request from the register slave,
// drives SCLK/MOSI/SS, shifts in MISO and returns the received byte with a
// one-cycle rec_data strobe.
//   pclk, preset        : clock, synchronous active-high reset
//   bus (slave modport) : send_data_i, mosi_data_i, miso_data_o, rec_data_o, tip_o
//   mstr_i, cpol_i, cpha_i, lsbfe_i : master enable, polarity, phase, LSB first
//   sppr_i, spr_i       : baud prescaler / exponent, H = (sppr+1)*2^spr
//   spi_mode_i          : 00 RUN, 01 WAIT, 10 STOP, 11 RUN
//   miso_i              : serial input
//   loopback_i          : (SPI_LOOPBACK_EN only) sample MOSI instead of MISO
//   sclk_o, mosi_o, ss_o: serial clock, data out, active-low slave select
// Optional feature macro: SPI_LOOPBACK_EN.
// -----------------------------------------------------------------------------
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    spi_shift_engine_if.slave bus,
    input  logic              mstr_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic [2:0]        sppr_i,
    input  logic [2:0]        spr_i,
    input  logic [1:0]        spi_mode_i,
    input  logic              miso_i,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              ss_o
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam int               EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    logic [1:0]          state_reg;
    logic [EDGE_W-1:0]   edge_reg;
    logic [DATA_W-1:0]   tx_reg;
    logic [DATA_W-1:0]   rx_reg;
    logic [DATA_W-1:0]   miso_data_reg;
    logic [HP_CNT_W-1:0] hp_reg;
    logic                cpol_reg, cpha_reg, lsbfe_reg;
    logic                sclk_reg, mosi_reg, ss_reg, tip_reg, rec_reg;

    logic              stop_mode;
    logic              start;
    logic              edge_tick;
    logic              is_lead;
    logic              sample_now;
    logic              shift_now;
    logic              sample_bit;
    logic [DATA_W-1:0] rx_msb_next;
    logic [DATA_W-1:0] rx_lsb_next;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    always_comb begin
        stop_mode = 1'b0;
        case (spi_mode_i)
            SPI_STOP:          stop_mode = 1'b1;
            SPI_RUN, SPI_WAIT: stop_mode = 1'b0;
            default:           stop_mode = 1'b0;   // 11 behaves as RUN
        endcase
    end

`ifdef SPI_LOOPBACK_EN
    assign sample_bit = loopback_i ? mosi_reg : miso_i;
`else
    assign sample_bit = miso_i;
`endif

    assign start = (state_reg == IDLE) && bus.send_data_i && mstr_i && !stop_mode;

    // Even edge index is the leading SCLK edge of a bit, odd is trailing.
    assign is_lead    = ~edge_reg[0];
    assign sample_now = edge_tick && (cpha_reg ? !is_lead : is_lead);
    // With CPHA=0 the first bit is already on MOSI, so no shift follows the final edge.
    assign shift_now  = edge_tick && (cpha_reg ? is_lead : (!is_lead && edge_reg != LAST_EDGE));

    // Receive assembly in both bit orders; the latched lsbfe picks one.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rx
            if (gi == 0) begin : g_msb_in
                assign rx_msb_next[gi] = sample_bit;
            end else begin : g_msb_sh
                assign rx_msb_next[gi] = rx_reg[gi-1];
            end
            if (gi == DATA_W - 1) begin : g_lsb_in
                assign rx_lsb_next[gi] = sample_bit;
            end else begin : g_lsb_sh
                assign rx_lsb_next[gi] = rx_reg[gi+1];
            end
        end
    endgenerate

    spi_baud_gen u_baud (
        .pclk        (pclk),
        .preset      (preset),
        .half_period (hp_reg),
        .enable      (state_reg == SHIFT),
        .freeze      (stop_mode),
        .clear       (state_reg != SHIFT),
        .edge_tick   (edge_tick)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg     <= IDLE;
            edge_reg      <= '0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            miso_data_reg <= '0;
            hp_reg        <= '0;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            lsbfe_reg     <= 1'b0;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
            ss_reg        <= 1'b1;
            tip_reg       <= 1'b0;
            rec_reg       <= 1'b0;
        end else begin
            rec_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sclk_reg <= cpol_i;
                    if (start) begin
                        state_reg <= SHIFT;
                        ss_reg    <= 1'b0;
                        tip_reg   <= 1'b1;
                        edge_reg  <= '0;
                        rx_reg    <= '0;
                        cpol_reg  <= cpol_i;
                        cpha_reg  <= cpha_i;
                        lsbfe_reg <= lsbfe_i;
                        hp_reg    <= half_period(sppr_i, spr_i);
                        if (!cpha_i) begin
                            mosi_reg <= first_bit(bus.mosi_data_i, lsbfe_i);
                            tx_reg   <= shift_out(bus.mosi_data_i, lsbfe_i);
                        end else begin
                            tx_reg   <= bus.mosi_data_i;
                        end
                    end
                end
                SHIFT: begin
                    if (!mstr_i) begin
                        // Abort has priority over everything, including the final edge.
                        state_reg <= IDLE;
                        ss_reg    <= 1'b1;
                        tip_reg   <= 1'b0;
                        sclk_reg  <= cpol_reg;
                    end else if (edge_tick) begin
                        sclk_reg <= ~sclk_reg;
                        edge_reg <= edge_reg + EDGE_W'(1);
                        if (sample_now) begin
                            rx_reg <= lsbfe_reg ? rx_lsb_next : rx_msb_next;
                        end
                        if (shift_now) begin
                            mosi_reg <= first_bit(tx_reg, lsbfe_reg);
                            tx_reg   <= shift_out(tx_reg, lsbfe_reg);
                        end
                        if (edge_reg == LAST_EDGE) begin
                            state_reg <= DONE;
                            ss_reg    <= 1'b1;
                            tip_reg   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    rec_reg       <= 1'b1;
                    miso_data_reg <= rx_reg;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sclk_o          = sclk_reg;
    assign mosi_o          = mosi_reg;
    assign ss_o            = ss_reg;
    assign bus.tip_o       = tip_reg;
    assign bus.rec_data_o  = rec_reg;
    assign bus.miso_data_o = miso_data_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
// Directed bench for spi_shift_engine: a behavioural SPI slave drives MISO
// from observed SCLK edges, MOSI is captured on the receiving edge, and
// pin/handshake timing is counted per pclk cycle.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

    logic       pclk;
    logic       preset;
    logic       mstr_i, cpol_i, cpha_i, lsbfe_i;
    logic [2:0] sppr_i, spr_i;
    logic [1:0] spi_mode_i;
    logic       miso_i;
    logic       sclk_o, mosi_o, ss_o;
`ifdef SPI_LOOPBACK_EN
    logic       loopback_i;
`endif

    spi_shift_engine_if #(.DATA_W(8)) bus ();

    spi_shift_engine #(.DATA_W(8)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .bus        (bus.slave),
        .mstr_i     (mstr_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .lsbfe_i    (lsbfe_i),
        .sppr_i     (sppr_i),
        .spr_i      (spr_i),
        .spi_mode_i (spi_mode_i),
        .miso_i     (miso_i),
`ifdef SPI_LOOPBACK_EN
        .loopback_i (loopback_i),
`endif
        .sclk_o     (sclk_o),
        .mosi_o     (mosi_o),
        .ss_o       (ss_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    // Per-transfer observations
    int          tip_cnt, ss_cnt, rise_cnt, rise_period, rec_cnt, fall_c, rec_c, first_rise_c;
    logic [7:0]  rec_val, mosi_byte;
    logic        frozen_ok, abort_ok, first_ok;
    logic [12:0] rst_vec;

    // Runs one transfer. Negative edge arguments disable that event; an event
    // at edge e fires on the cycle the (e+1)-th SCLK transition is seen.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] slv,
                        input logic cp, input logic ph, input logic lf,
                        input logic [2:0] pp, input logic [2:0] sp,
                        input int stop_edge, input int stop_len,
                        input int abort_edge, input int rst_edge, input int pulse_edge);
        int         edges, lead, trail, nb, k, stop_left, act_c, post, pulse_c;
        logic       prev_sclk, prev_tip, stop_done, pulse_done, frz_sclk, frz_mosi;
        logic [7:0] seq;
        tip_cnt = 0; ss_cnt = 0; rise_cnt = 0; rise_period = 0; rec_cnt = 0;
        fall_c = -1; rec_c = -1; first_rise_c = -1; rec_val = 8'h00;
        frozen_ok = 1'b1; abort_ok = 1'b0; first_ok = 1'b0; rst_vec = '1;
        edges = 0; lead = 0; trail = 0; nb = 0; stop_left = 0; act_c = -1; post = 0;
        pulse_c = -1; stop_done = 1'b0; pulse_done = 1'b0; frz_sclk = 1'b0; frz_mosi = 1'b0;
        seq = 8'h00;
        mstr_i = 1'b1; cpol_i = cp; cpha_i = ph; lsbfe_i = lf;
        sppr_i = pp; spr_i = sp; spi_mode_i = 2'b00;
        miso_i = lf ? slv[0] : slv[7];
        repeat (2) @(negedge pclk);
        bus.mosi_data_i = tx;
        bus.send_data_i = 1'b1;
        prev_sclk = sclk_o;
        prev_tip  = 1'b0;
        @(negedge pclk);
        bus.send_data_i = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 0) first_ok = (bus.tip_o == 1'b1) && (ss_o == 1'b0);
            if (bus.tip_o) tip_cnt++;
            if (!ss_o) ss_cnt++;
            if (bus.rec_data_o) begin
                rec_cnt++;
                rec_val = bus.miso_data_o;
                rec_c = c;
            end
            if (prev_tip && !bus.tip_o && fall_c < 0) fall_c = c;
            if (sclk_o != prev_sclk && act_c < 0) begin
                edges++;
                if (sclk_o) begin
                    rise_cnt++;
                    if (first_rise_c < 0) first_rise_c = c;
                    else if (rise_period == 0) rise_period = c - first_rise_c;
                end
                if (sclk_o != cp) begin
                    lead++;
                    if (!ph && nb < 8) begin seq[nb] = mosi_o; nb++; end
                end else begin
                    trail++;
                    if (ph && nb < 8) begin seq[nb] = mosi_o; nb++; end
                end
            end
            prev_sclk = sclk_o;
            prev_tip  = bus.tip_o;
            // Slave: CPHA=0 changes data on trailing edges, CPHA=1 on leading edges.
            k = ph ? ((lead > 0) ? lead - 1 : 0) : trail;
            if (k > 7) k = 7;
            miso_i = lf ? slv[k] : slv[7-k];

            if (pulse_edge >= 0 && !pulse_done && edges == pulse_edge + 1) begin
                bus.send_data_i = 1'b1;
                bus.mosi_data_i = ~tx;
                pulse_done = 1'b1;
                pulse_c = c;
            end else if (pulse_done && c == pulse_c + 1) begin
                bus.send_data_i = 1'b0;
            end

            if (stop_left > 0) begin
                if (sclk_o !== frz_sclk || mosi_o !== frz_mosi) frozen_ok = 1'b0;
                stop_left--;
                if (stop_left == 0) spi_mode_i = 2'b00;
            end else if (stop_edge >= 0 && !stop_done && edges == stop_edge + 1) begin
                spi_mode_i = 2'b10;
                stop_left = stop_len;
                frz_sclk = sclk_o;
                frz_mosi = mosi_o;
                stop_done = 1'b1;
            end

            if (act_c >= 0 && c == act_c + 1) begin
                if (abort_edge >= 0) begin
                    abort_ok = ss_o && !bus.tip_o && (sclk_o == cp);
                    mstr_i = 1'b1;
                end else begin
                    rst_vec = {sclk_o, mosi_o, ss_o, bus.tip_o, bus.rec_data_o, bus.miso_data_o};
                    preset = 1'b0;
                end
            end
            if (act_c < 0 && abort_edge >= 0 && edges == abort_edge + 1) begin
                mstr_i = 1'b0;
                act_c = c;
            end
            if (act_c < 0 && rst_edge >= 0 && edges == rst_edge + 1) begin
                preset = 1'b1;
                act_c = c;
            end

            if (fall_c >= 0) begin
                post++;
                if (post > 3) break;
            end
            @(negedge pclk);
        end
        check("xfer_end_seen", (fall_c >= 0), 1);
        for (int j = 0; j < 8; j++) begin
            if (lf) mosi_byte[j] = seq[j];
            else    mosi_byte[7-j] = seq[j];
        end
    endtask

    initial begin
        preset = 1'b1;
        mstr_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0;
        sppr_i = 3'd0; spr_i = 3'd0; spi_mode_i = 2'b00; miso_i = 1'b0;
        bus.send_data_i = 1'b0; bus.mosi_data_i = 8'h00;
`ifdef SPI_LOOPBACK_EN
        loopback_i = 1'b0;
`endif
        repeat (3) @(negedge pclk);
        check("reset_state", {sclk_o, mosi_o, ss_o, bus.tip_o, bus.rec_data_o, bus.miso_data_o},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        preset = 1'b0;
        cpol_i = 1'b1;
        repeat (2) @(negedge pclk);
        check("idle_sclk_follows_cpol", sclk_o, 1);
        cpol_i = 1'b0;
        repeat (2) @(negedge pclk);

        // H=1, mode 0, MSB first
        xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0, -1, -1, -1);
        check("t1_start_latency", first_ok, 1);
        check("t1_mosi", mosi_byte, 8'hA5);
        check("t1_sclk_rises", rise_cnt, 8);
        check("t1_tip_cycles", tip_cnt, 16);
        check("t1_ss_low_cycles", ss_cnt, 16);
        check("t1_rec_pulses", rec_cnt, 1);
        check("t1_rec_data", rec_val, 8'h3C);
        check("t1_rec_after_tip", rec_c - fall_c, 1);
        check("t1_miso_data_held", bus.miso_data_o, 8'h3C);

        // H=6, all ones, with an ignored send pulse mid-transfer
        xfer(8'hFF, 8'h96, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, -1, 0, -1, -1, 3);
        check("t2_sclk_period", rise_period, 12);
        check("t2_tip_cycles", tip_cnt, 96);
        check("t2_ss_low_cycles", ss_cnt, 96);
        check("t2_mosi", mosi_byte, 8'hFF);
        check("t2_rec_data", rec_val, 8'h96);
        check("t2_rec_pulses", rec_cnt, 1);

        // CPOL=1, CPHA=1, LSB first, H=2
        xfer(8'h81, 8'h42, 1'b1, 1'b1, 1'b1, 3'd1, 3'd0, -1, 0, -1, -1, -1);
        check("t3_mosi", mosi_byte, 8'h81);
        check("t3_rec_data", rec_val, 8'h42);
        check("t3_tip_cycles", tip_cnt, 32);
        check("t3_sclk_rises", rise_cnt, 8);
        check("t3_sclk_idle_high", sclk_o, 1);

        // H=2, STOP for 10 cycles after edge 5
        xfer(8'hC3, 8'h5E, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 5, 10, -1, -1, -1);
        check("t4_tip_cycles", tip_cnt, 42);
        check("t4_frozen", frozen_ok, 1);
        check("t4_mosi", mosi_byte, 8'hC3);
        check("t4_rec_data", rec_val, 8'h5E);

        // Abort at edge 7
        xfer(8'h12, 8'h77, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0, 7, -1, -1);
        check("t5_abort_pins", abort_ok, 1);
        check("t5_tip_cycles", tip_cnt, 9);
        check("t5_no_rec", rec_cnt, 0);
        check("t5_miso_unchanged", bus.miso_data_o, 8'h5E);

        // Reset at edge 9, then a normal transfer
        xfer(8'h33, 8'h99, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0, -1, 9, -1);
        check("t6_reset_outputs", rst_vec, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        check("t6_no_rec", rec_cnt, 0);
        xfer(8'h5A, 8'hA3, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, -1, 0, -1, -1, -1);
        check("t6_after_mosi", mosi_byte, 8'h5A);
        check("t6_after_rec_data", rec_val, 8'hA3);
        check("t6_after_tip_cycles", tip_cnt, 16);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
